// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - store type encodings and FIFO entry sizing for the store buffer
package store_pkg;

    localparam logic [2:0] ST_SB = 3'b001;
    localparam logic [2:0] ST_SH = 3'b010;
    localparam logic [2:0] ST_SW = 3'b011;

    localparam int AW_DEFAULT = 32;
    localparam int ENTRY_W    = AW_DEFAULT - 2 + 32 + 4;

    // Entry = word address bits, lane-steered data, byte strobes
    function automatic int entry_width(input int aw);
        return aw - 2 + 32 + 4;
    endfunction

endpackage

// File: rtl/store_aligner.sv
// rtl/store_aligner.sv - steers store data onto byte lanes and flags misaligned or invalid stores
module store_aligner
    import store_pkg::*;
(
    input  logic [2:0]  store_type,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        misaligned
);

    always_comb begin
        wdata      = '0;
        wstrb      = '0;
        misaligned = 1'b1;
        case (store_type)
            ST_SB: begin
                wdata      = {4{store_data[7:0]}};
                wstrb      = 4'b0001 << offset;
                misaligned = 1'b0;
            end
            ST_SH: begin
                wdata      = {2{store_data[15:0]}};
                wstrb      = offset[1] ? 4'b1100 : 4'b0011;
                misaligned = offset[0];
            end
            ST_SW: begin
                wdata      = store_data;
                wstrb      = 4'b1111;
                misaligned = (offset != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO between MEM stage and data memory with req/ack drain
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [2:0]    StoreType,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   StoreData,
    output logic          st_misaligned,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_ack,
    output logic          sb_empty
);

    localparam int         PW      = $clog2(DEPTH);
    localparam int         EW      = entry_width(AW);
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    logic [EW-1:0] fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          mis_q;

    logic [31:0]   al_wdata;
    logic [3:0]    al_wstrb;
    logic          al_mis;
    logic          accept;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    store_aligner u_aligner (
        .store_type (StoreType),
        .offset     (st_addr[1:0]),
        .store_data (StoreData),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .misaligned (al_mis)
    );

    // Outputs are functions of registered count only; no path from st_* or mem_ack
    assign st_ready = (count < DEPTH_C);
    assign sb_empty = (count == '0);
    assign mem_req  = !sb_empty;

    assign accept = st_valid && st_ready;
    assign push   = accept && !al_mis;
    assign pop    = mem_req && mem_ack;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= {st_addr[AW-1:2], al_wdata, al_wstrb};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mis_q  <= 1'b0;
        end else begin
            mis_q <= accept && al_mis;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign st_misaligned = mis_q;

    // Storage is not reset, so the head is masked to zero whenever nothing is queued
    assign head      = fifo_q[rd_ptr];
    assign mem_addr  = mem_req ? {head[EW-1:36], 2'b00} : '0;
    assign mem_wdata = mem_req ? head[35:4] : '0;
    assign mem_wstrb = mem_req ? head[3:0] : '0;

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer with directed store vectors
module tb_store_buffer;

    logic        clk;
    logic        reset_n;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  StoreType;
    logic [31:0] st_addr;
    logic [31:0] StoreData;
    logic        st_misaligned;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic        sb_empty;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .StoreType     (StoreType),
        .st_addr       (st_addr),
        .StoreData     (StoreData),
        .st_misaligned (st_misaligned),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ack       (mem_ack),
        .sb_empty      (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] es);
        exp_t e;
        e.a = ea; e.d = ew; e.s = es;
        exp_q.push_back(e);
        st_valid = 1'b1; StoreType = t; st_addr = a; StoreData = d;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic reject(input string name, input logic [2:0] t, input logic [31:0] a);
        st_valid = 1'b1; StoreType = t; st_addr = a; StoreData = 32'hCAFEF00D;
        tick();
        st_valid = 1'b0;
        check({name, "_mis_pulse"}, st_misaligned, 1'b1);
        check({name, "_req_low"}, mem_req, 1'b0);
        tick();
        check({name, "_mis_clear"}, st_misaligned, 1'b0);
        check({name, "_empty"}, sb_empty, 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        mem_ack = 1'b1;
        while (!sb_empty && n < 60) begin
            tick();
            n++;
        end
        mem_ack = 1'b0;
        check({name, "_drained"}, sb_empty, 1'b1);
        check({name, "_sb_left"}, exp_q.size(), 0);
    endtask

    // Monitor: compares each accepted head against the scoreboard and checks hold stability
    logic        hold;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wstrb;
    initial hold = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_addr", mem_addr, p_addr);
                check("hold_wdata", mem_wdata, p_wdata);
                check("hold_wstrb", mem_wstrb, p_wstrb);
            end
            if (mem_req && exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_req actual addr=0x%0h expected no request", mem_addr);
            end else if (mem_req && mem_ack) begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_addr", mem_addr, e.a);
                check("mon_wdata", mem_wdata, e.d);
                check("mon_wstrb", mem_wstrb, e.s);
            end
            hold = mem_req && !mem_ack;
            p_addr = mem_addr; p_wdata = mem_wdata; p_wstrb = mem_wstrb;
        end
    end

    initial begin
        reset_n = 1'b0; st_valid = 1'b0; StoreType = 3'b000;
        st_addr = '0; StoreData = '0; mem_ack = 1'b0;
        #2;
        check("rst_ready", st_ready, 1'b1);
        check("rst_req", mem_req, 1'b0);
        check("rst_mis", st_misaligned, 1'b0);
        check("rst_empty", sb_empty, 1'b1);
        check("rst_mem", {mem_addr, mem_wdata, mem_wstrb}, '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // 1: single SW, acked the cycle after it becomes visible
        begin
            exp_t e;
            e.a = 32'h100; e.d = 32'hDEADBEEF; e.s = 4'b1111;
            exp_q.push_back(e);
        end
        st_valid = 1'b1; StoreType = 3'b011; st_addr = 32'h100; StoreData = 32'hDEADBEEF;
        check("t1_no_bypass", mem_req, 1'b0);
        tick();
        st_valid = 1'b0; mem_ack = 1'b1;
        check("t1_req", mem_req, 1'b1);
        check("t1_not_empty", sb_empty, 1'b0);
        tick();
        mem_ack = 1'b0;
        check("t1_empty", sb_empty, 1'b1);

        // 2: byte and halfword lane steering
        mem_ack = 1'b1;
        push(3'b001, 32'h103, 32'h123456AB, 32'h100, 32'hABABABAB, 4'b1000);
        push(3'b010, 32'h206, 32'h0000BEEF, 32'h204, 32'hBEEFBEEF, 4'b1100);
        push(3'b001, 32'h0A1, 32'h000000C3, 32'h0A0, 32'hC3C3C3C3, 4'b0010);
        push(3'b010, 32'h0B0, 32'h00001234, 32'h0B0, 32'h12341234, 4'b0011);
        drain("t2");

        // 3: rejected stores
        reject("t3_sh", 3'b010, 32'h101);
        reject("t3_sw", 3'b011, 32'h102);
        reject("t3_inv", 3'b111, 32'h100);

        // 4: fill with no ack, blocked 5th store, single pop, ordered drain
        mem_ack = 1'b0;
        push(3'b011, 32'h300, 32'h11111111, 32'h300, 32'h11111111, 4'b1111);
        push(3'b011, 32'h304, 32'h22222222, 32'h304, 32'h22222222, 4'b1111);
        push(3'b011, 32'h308, 32'h33333333, 32'h308, 32'h33333333, 4'b1111);
        push(3'b011, 32'h30C, 32'h44444444, 32'h30C, 32'h44444444, 4'b1111);
        check("t4_full", st_ready, 1'b0);
        check("t4_head0", mem_addr, 32'h300);
        st_valid = 1'b1; StoreType = 3'b011; st_addr = 32'h310; StoreData = 32'h55555555;
        tick();
        tick();
        st_valid = 1'b0;
        check("t4_still_full", st_ready, 1'b0);
        check("t4_head0_held", mem_wdata, 32'h11111111);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t4_head1", mem_addr, 32'h304);
        check("t4_ready_again", st_ready, 1'b1);
        drain("t4");

        // 5: push and pop together at count 1, across pointer wrap
        push(3'b011, 32'h400, 32'hA0000000, 32'h400, 32'hA0000000, 4'b1111);
        for (int i = 1; i <= 10; i++) begin
            mem_ack = 1'b1;
            check("t5_ready", st_ready, 1'b1);
            push(3'b011, 32'h400 + 32'(4 * i), 32'hA0000000 + 32'(i),
                 32'h400 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'b1111);
            check("t5_count1", {sb_empty, st_ready}, 2'b01);
            check("t5_head", mem_addr, 32'h400 + 32'(4 * i));
        end
        mem_ack = 1'b0;
        drain("t5");

        // 6: reset with stores queued
        push(3'b011, 32'h500, 32'h1, 32'h500, 32'h1, 4'b1111);
        push(3'b011, 32'h504, 32'h2, 32'h504, 32'h2, 4'b1111);
        push(3'b011, 32'h508, 32'h3, 32'h508, 32'h3, 4'b1111);
        check("t6_pending", mem_req, 1'b1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_req_drop", mem_req, 1'b0);
        check("t6_ready", st_ready, 1'b1);
        tick();
        reset_n = 1'b1;
        check("t6_empty", sb_empty, 1'b1);
        mem_ack = 1'b1;
        repeat (4) tick();
        mem_ack = 1'b0;
        check("t6_no_stale", {mem_req, sb_empty}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
